// File: rtl/bm_norm_pkg.sv
// Shared bias helpers, default lane widths and lane types for the block-minifloat normaliser.
package bm_norm_pkg;

  localparam int unsigned DefBmExpW  = 4;
  localparam int unsigned DefBmManW  = 10;
  localparam int unsigned DefFpExpW  = 8;
  localparam int unsigned DefFpManW  = 23;
  localparam int unsigned DefBmLaneW = 1 + DefBmExpW + DefBmManW;
  localparam int unsigned DefFpLaneW = 1 + DefFpExpW + DefFpManW;

  function automatic int bm_bias(input int unsigned exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_bias(input int unsigned exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  typedef struct packed {
    logic                 sign;
    logic [DefBmExpW-1:0] exp;
    logic [DefBmManW-1:0] mant;
  } bm_lane_t;

  typedef struct packed {
    logic ovf;
    logic unf;
  } lane_flags_t;

endpackage

// File: rtl/bm_lane_convert.sv
// One lane of the (e,m)+shared-bias to (E,M) conversion, two register stages.
// Define BM_NORM_RNE_EN for round-to-nearest-even when M < m; otherwise truncate.
module bm_lane_convert
  import bm_norm_pkg::*;
#(
  parameter int unsigned e = 4,
  parameter int unsigned m = 10,
  parameter int unsigned E = 8,
  parameter int unsigned M = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s1_en,
  input  logic         s2_en,
  input  logic [e+m:0] lane_in,
  input  logic [e-1:0] shared_bias,
  output logic [E+M:0] lane_out,
  output logic         ovf,
  output logic         unf
);

  localparam int unsigned W = ((e > E) ? e : E) + 3;
  localparam logic signed [W-1:0] BiasDelta    = W'(fp_bias(E) - bm_bias(e));
  localparam logic signed [W-1:0] XMax         = W'((1 << E) - 1);
  localparam logic [E-1:0]        ExpMaxFinite = E'((1 << E) - 2);

  logic         in_sign;
  logic [e-1:0] in_exp;
  logic [m-1:0] in_mant;
  assign {in_sign, in_exp, in_mant} = lane_in;

  logic signed [W-1:0] sb_ext;
  assign sb_ext = {{(W - e){shared_bias[e-1]}}, shared_bias};

  // Stage 1: decode, leading-one detect, biased output exponent.
  logic signed [W-1:0] x_d, x_q;
  logic [m-1:0]        frac_d, frac_q;
  logic                zero_d, zero_q, sign_q;
  int                  lz;

  always_comb begin
    lz = m;
    for (int i = 0; i < m; i++) begin
      if (in_mant[i]) lz = m - 1 - i;
    end
    zero_d = (in_exp == '0) && (in_mant == '0);
    if (in_exp != '0) begin
      x_d    = W'(in_exp) + sb_ext + BiasDelta;
      frac_d = in_mant;
    end else begin
      // Subnormal: shift the leading one out into the hidden-bit position.
      x_d    = W'(1) + sb_ext + BiasDelta - W'(lz + 1);
      frac_d = in_mant << (lz + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      x_q    <= '0;
      frac_q <= '0;
    end else if (s1_en) begin
      sign_q <= in_sign;
      zero_q <= zero_d;
      x_q    <= x_d;
      frac_q <= frac_d;
    end
  end

  // Stage 2: align/round the mantissa, range-check, pack.
  logic [M-1:0] mant_t;
  logic         round_up;

  if (M >= m) begin : g_pad
    assign mant_t   = M'(frac_q) << (M - m);
    assign round_up = 1'b0;
  end else begin : g_cut
    assign mant_t = frac_q[m-1 -: M];
`ifdef BM_NORM_RNE_EN
    logic guard, sticky;
    assign guard = frac_q[m-M-1];
    if (m - M >= 2) begin : g_sticky
      assign sticky = |frac_q[m-M-2:0];
    end else begin : g_no_sticky
      assign sticky = 1'b0;
    end
    assign round_up = guard & (sticky | mant_t[0]);
`else
    assign round_up = 1'b0;
`endif
  end

  logic [M:0]          mant_sum;
  logic signed [W-1:0] x_r;
  logic [E+M:0]        out_d, out_q;
  lane_flags_t         flags_d, flags_q;

  always_comb begin
    mant_sum    = {1'b0, mant_t} + (M + 1)'(round_up);
    // A carry out of the mantissa leaves it zero and bumps the exponent.
    x_r         = x_q + W'(mant_sum[M]);
    out_d       = '0;
    out_d[E+M]  = sign_q;
    flags_d     = '0;
    if (zero_q) begin
      flags_d = '0;
    end else if (x_r >= XMax) begin
      out_d       = {sign_q, ExpMaxFinite, {M{1'b1}}};
      flags_d.ovf = 1'b1;
    end else if (x_r[W-1] || (x_r == '0)) begin
      flags_d.unf = 1'b1;
    end else begin
      out_d = {sign_q, x_r[E-1:0], mant_sum[M-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      flags_q <= '0;
    end else if (s2_en) begin
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign lane_out = out_q;
  assign ovf      = flags_q.ovf;
  assign unf      = flags_q.unf;

endmodule

// File: rtl/bm_block_normalizer.sv
// Multi-lane block-minifloat to IEEE-style normaliser: 2-stage valid/ready pipeline.
// Rounding mode of the lanes is selected by BM_NORM_RNE_EN (see bm_lane_convert).
module bm_block_normalizer
  import bm_norm_pkg::*;
#(
  parameter int unsigned e     = 4,
  parameter int unsigned m     = 10,
  parameter int unsigned E     = 8,
  parameter int unsigned M     = 23,
  parameter int unsigned LANES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*(1+e+m)-1:0]     in_data,
  input  logic [e-1:0]                 in_shared_bias,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*(1+E+M)-1:0]     out_data,
  output logic                         out_last,
  output logic [LANES-1:0]             out_ovf,
  output logic [LANES-1:0]             out_unf,
  input  logic                         clear_sticky,
  output logic                         ovf_sticky,
  output logic                         unf_sticky
);

  localparam int unsigned InW  = 1 + e + m;
  localparam int unsigned OutW = 1 + E + M;

  logic s1_valid_q, s2_valid_q, s1_last_q, out_last_q;
  logic s1_ready, s2_ready, s1_en, s2_en;
  logic ovf_sticky_q, unf_sticky_q;

  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign s1_en    = in_valid && s1_ready;
  assign s2_en    = s1_valid_q && s2_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      if (s1_ready) s1_valid_q <= in_valid;
      if (s2_ready) s2_valid_q <= s1_valid_q;
      if (s1_en)    s1_last_q  <= in_last;
      if (s2_en)    out_last_q <= s1_last_q;
    end
  end

  // Clear wins over a set landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clear_sticky) begin
      ovf_sticky_q <= 1'b0;
      unf_sticky_q <= 1'b0;
    end else if (s2_valid_q && out_ready) begin
      ovf_sticky_q <= ovf_sticky_q | (|out_ovf);
      unf_sticky_q <= unf_sticky_q | (|out_unf);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bm_lane_convert #(
      .e(e),
      .m(m),
      .E(E),
      .M(M)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .s1_en      (s1_en),
      .s2_en      (s2_en),
      .lane_in    (in_data[i*InW +: InW]),
      .shared_bias(in_shared_bias),
      .lane_out   (out_data[i*OutW +: OutW]),
      .ovf        (out_ovf[i]),
      .unf        (out_unf[i])
    );
  end

  assign in_ready   = s1_ready;
  assign out_valid  = s2_valid_q;
  assign out_last   = out_last_q;
  assign ovf_sticky = ovf_sticky_q;
  assign unf_sticky = unf_sticky_q;

endmodule
